// File: rtl/jedro_1_load_unit_if.sv
// Load-unit bus: request from execute, data-memory read port, writeback and error reporting.
// state_dbg exposes the unit's FSM state for checkers.
interface jedro_1_load_unit_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // Handshake: a request transfers at a rising edge where req_valid_i && req_ready_o;
  // the requester holds its fields stable while req_valid_i is high and not yet accepted.
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [2:0]                req_funct3_i;
  logic [ADDR_WIDTH-1:0]     req_addr_i;
  logic [REG_ADDR_WIDTH-1:0] req_rd_i;
  logic                      mem_en_o;
  logic [ADDR_WIDTH-1:0]     mem_addr_o;
  logic [DATA_WIDTH-1:0]     mem_rdata_i;
  logic                      wb_valid_o;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_o;
  logic [DATA_WIDTH-1:0]     wb_data_o;
  logic                      err_misaligned_o;
  logic                      err_illegal_o;
  logic [ADDR_WIDTH-1:0]     err_addr_o;
  logic [2:0]                state_dbg;

  modport slave (
    input  req_valid_i, req_funct3_i, req_addr_i, req_rd_i, mem_rdata_i,
    output req_ready_o, mem_en_o, mem_addr_o, wb_valid_o, wb_rd_o, wb_data_o,
           err_misaligned_o, err_illegal_o, err_addr_o, state_dbg
  );

  modport master (
    output req_valid_i, req_funct3_i, req_addr_i, req_rd_i, mem_rdata_i,
    input  req_ready_o, mem_en_o, mem_addr_o, wb_valid_o, wb_rd_o, wb_data_o,
           err_misaligned_o, err_illegal_o, err_addr_o, state_dbg
  );
endinterface

// File: rtl/jedro_1_load_unit.sv
// jedro_1 load unit: one aligned word read per load, lane extraction with sign/zero
// extension after READ_LATENCY cycles, misaligned and illegal-funct3 detection.
module jedro_1_load_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int READ_LATENCY   = 1
) (
  input logic                  clk_i,
  input logic                  rstn_i,
  jedro_1_load_unit_if.slave   bus
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                    state;
  logic [2:0]                f3_q;
  logic [OFF_W-1:0]          off_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [2:0]                cnt;
  logic                      accept;
  logic                      illegal;
  logic                      misaligned;
  logic [DATA_WIDTH-1:0]     shifted;
  logic [DATA_WIDTH-1:0]     lane;

  // Ready is gated by reset so it reads 0 for the whole time rstn_i is low.
  assign bus.req_ready_o = rstn_i && (state == S_IDLE || state == S_RESP);
  assign accept          = bus.req_valid_i && bus.req_ready_o;
  assign bus.state_dbg   = state;

  always_comb begin
    illegal = 1'b0;
    case (bus.req_funct3_i)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
      3'b011, 3'b110:                         illegal = (DATA_WIDTH != 64);
      default:                                illegal = 1'b1;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_funct3_i)
      3'b001, 3'b101: misaligned = bus.req_addr_i[0];
      3'b010, 3'b110: misaligned = |bus.req_addr_i[1:0];
      3'b011:         misaligned = |bus.req_addr_i[2:0];
      default:        misaligned = 1'b0;
    endcase
  end

  assign shifted = bus.mem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    lane = shifted;
    case (f3_q)
      3'b000:  lane = DATA_WIDTH'($signed(shifted[7:0]));
      3'b001:  lane = DATA_WIDTH'($signed(shifted[15:0]));
      3'b010:  lane = DATA_WIDTH'($signed(shifted[31:0]));
      3'b100:  lane = DATA_WIDTH'(shifted[7:0]);
      3'b101:  lane = DATA_WIDTH'(shifted[15:0]);
      3'b110:  lane = DATA_WIDTH'(shifted[31:0]);
      default: lane = shifted;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state                <= S_IDLE;
      f3_q                 <= '0;
      off_q                <= '0;
      rd_q                 <= '0;
      cnt                  <= '0;
      bus.mem_en_o         <= 1'b0;
      bus.mem_addr_o       <= '0;
      bus.wb_valid_o       <= 1'b0;
      bus.wb_rd_o          <= '0;
      bus.wb_data_o        <= '0;
      bus.err_misaligned_o <= 1'b0;
      bus.err_illegal_o    <= 1'b0;
      bus.err_addr_o       <= '0;
    end else begin
      bus.mem_en_o         <= 1'b0;
      bus.wb_valid_o       <= 1'b0;
      bus.err_misaligned_o <= 1'b0;
      bus.err_illegal_o    <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            f3_q  <= bus.req_funct3_i;
            off_q <= bus.req_addr_i[OFF_W-1:0];
            rd_q  <= bus.req_rd_i;
            if (illegal || misaligned) begin
              // Illegal funct3 wins: misaligned is only reported for legal encodings.
              bus.err_illegal_o    <= illegal;
              bus.err_misaligned_o <= !illegal;
              bus.err_addr_o       <= bus.req_addr_i;
              state                <= S_ERR;
            end else begin
              bus.mem_en_o   <= 1'b1;
              bus.mem_addr_o <= {bus.req_addr_i[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
              state          <= S_ISSUE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          cnt   <= 3'(READ_LATENCY);
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          // cnt reaches 1 in cycle ISSUE+READ_LATENCY, when read data is valid.
          if (cnt == 3'd1) begin
            if (rd_q != '0) begin
              bus.wb_valid_o <= 1'b1;
              bus.wb_rd_o    <= rd_q;
              bus.wb_data_o  <= lane;
            end
            state <= S_RESP;
          end
        end
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jedro_1_load_unit.sv
// Directed bench for jedro_1_load_unit: three instances (32b/RL1, 32b/RL3, 64b/RL1),
// each with a small latency-accurate memory model.
module tb_jedro_1_load_unit;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];

  int men_cnt[3]  = '{default: 0};
  int men_cyc[3]  = '{default: 0};
  logic [31:0] men_addr[3];
  int wb_cnt[3]   = '{default: 0};
  int wb_cyc[3]   = '{default: 0};
  logic [63:0] wb_data[3];
  logic [4:0]  wb_rd[3];
  int ill_cnt[3]  = '{default: 0};
  int mis_cnt[3]  = '{default: 0};
  int err_cyc[3]  = '{default: 0};
  logic [31:0] err_addr[3];

  logic [31:0] sr[3][4];
  logic [3:0]  sv[3] = '{default: 4'b0};

  jedro_1_load_unit_if #(.DATA_WIDTH(32)) a ();
  jedro_1_load_unit_if #(.DATA_WIDTH(32)) b ();
  jedro_1_load_unit_if #(.DATA_WIDTH(64)) c ();

  jedro_1_load_unit #(.DATA_WIDTH(32), .READ_LATENCY(1)) dut_a (.clk_i(clk), .rstn_i(rstn), .bus(a));
  jedro_1_load_unit #(.DATA_WIDTH(32), .READ_LATENCY(3)) dut_b (.clk_i(clk), .rstn_i(rstn), .bus(b));
  jedro_1_load_unit #(.DATA_WIDTH(64), .READ_LATENCY(1)) dut_c (.clk_i(clk), .rstn_i(rstn), .bus(c));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem32(input logic [31:0] addr);
    case (addr & 32'hFFFF_FFFC)
      32'h0:   return 32'h8F7F_FF0F;
      32'h4:   return 32'h0000_0080;
      default: return 32'h5A5A_5A5A;
    endcase
  endfunction

  function automatic logic [63:0] mem64(input logic [31:0] addr);
    case (addr & 32'hFFFF_FFF8)
      32'h8:   return 64'h8000_0000_0000_0001;
      default: return 64'h5A5A_5A5A_5A5A_5A5A;
    endcase
  endfunction

  always @(posedge clk) begin
    sv[0] <= {sv[0][2:0], a.mem_en_o};
    sv[1] <= {sv[1][2:0], b.mem_en_o};
    sv[2] <= {sv[2][2:0], c.mem_en_o};
    sr[0][0] <= a.mem_addr_o;
    sr[1][0] <= b.mem_addr_o;
    sr[2][0] <= c.mem_addr_o;
    for (int k = 1; k < 4; k++) begin
      sr[0][k] <= sr[0][k-1];
      sr[1][k] <= sr[1][k-1];
      sr[2][k] <= sr[2][k-1];
    end
  end

  assign a.mem_rdata_i = sv[0][0] ? mem32(sr[0][0]) : 32'hDEAD_BEEF;
  assign b.mem_rdata_i = sv[1][2] ? mem32(sr[1][2]) : 32'hDEAD_BEEF;
  assign c.mem_rdata_i = sv[2][0] ? mem64(sr[2][0]) : 64'hDEAD_BEEF_DEAD_BEEF;

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (a.mem_en_o) begin men_cnt[0] <= men_cnt[0] + 1; men_cyc[0] <= cyc; men_addr[0] <= a.mem_addr_o; end
    if (b.mem_en_o) begin men_cnt[1] <= men_cnt[1] + 1; men_cyc[1] <= cyc; men_addr[1] <= b.mem_addr_o; end
    if (c.mem_en_o) begin men_cnt[2] <= men_cnt[2] + 1; men_cyc[2] <= cyc; men_addr[2] <= c.mem_addr_o; end
    if (a.wb_valid_o) begin wb_cnt[0] <= wb_cnt[0] + 1; wb_cyc[0] <= cyc; wb_data[0] <= 64'(a.wb_data_o); wb_rd[0] <= a.wb_rd_o; end
    if (b.wb_valid_o) begin wb_cnt[1] <= wb_cnt[1] + 1; wb_cyc[1] <= cyc; wb_data[1] <= 64'(b.wb_data_o); wb_rd[1] <= b.wb_rd_o; end
    if (c.wb_valid_o) begin wb_cnt[2] <= wb_cnt[2] + 1; wb_cyc[2] <= cyc; wb_data[2] <= c.wb_data_o; wb_rd[2] <= c.wb_rd_o; end
    if (a.err_illegal_o)    ill_cnt[0] <= ill_cnt[0] + 1;
    if (c.err_illegal_o)    ill_cnt[2] <= ill_cnt[2] + 1;
    if (a.err_misaligned_o) mis_cnt[0] <= mis_cnt[0] + 1;
    if (c.err_misaligned_o) mis_cnt[2] <= mis_cnt[2] + 1;
    if (a.err_illegal_o || a.err_misaligned_o) begin err_cyc[0] <= cyc; err_addr[0] <= a.err_addr_o; end
    if (c.err_illegal_o || c.err_misaligned_o) begin err_cyc[2] <= cyc; err_addr[2] <= c.err_addr_o; end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input int sel, input logic v, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [4:0] rd);
    case (sel)
      0: begin a.req_valid_i = v; a.req_funct3_i = f3; a.req_addr_i = addr; a.req_rd_i = rd; end
      1: begin b.req_valid_i = v; b.req_funct3_i = f3; b.req_addr_i = addr; b.req_rd_i = rd; end
      default: begin c.req_valid_i = v; c.req_funct3_i = f3; c.req_addr_i = addr; c.req_rd_i = rd; end
    endcase
  endtask

  function automatic logic ready_of(input int sel);
    case (sel)
      0:       return a.req_ready_o;
      1:       return b.req_ready_o;
      default: return c.req_ready_o;
    endcase
  endfunction

  // One load; t is the cycle in which the request is presented with ready high.
  task automatic run_load(input int sel, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [63:0] exp,
                          input logic [31:0] exp_maddr, input string tag);
    int rl, t, men0, wb0;
    rl = (sel == 1) ? 3 : 1;
    @(negedge clk);
    drive(sel, 1'b1, f3, addr, rd);
    #1;
    t    = cyc;
    men0 = men_cnt[sel];
    wb0  = wb_cnt[sel];
    check({tag, "_ready"}, 64'(ready_of(sel)), 64'd1);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 3'b000, 32'h0, 5'd0);
    for (int i = 0; i < rl + 4; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_men_cnt"}, 64'(men_cnt[sel] - men0), 64'd1);
    check({tag, "_men_cyc"}, 64'(men_cyc[sel]), 64'(t + 1));
    check({tag, "_men_addr"}, 64'(men_addr[sel]), 64'(exp_maddr));
    if (rd != 5'd0) begin
      exp_q.push_back(exp);
      check({tag, "_wb_cnt"}, 64'(wb_cnt[sel] - wb0), 64'd1);
      check({tag, "_wb_cyc"}, 64'(wb_cyc[sel]), 64'(t + rl + 2));
      check({tag, "_wb_rd"}, 64'(wb_rd[sel]), 64'(rd));
      check({tag, "_wb_data"}, wb_data[sel], exp_q.pop_front());
    end else begin
      check({tag, "_wb_none"}, 64'(wb_cnt[sel] - wb0), 64'd0);
    end
  endtask

  task automatic run_err(input int sel, input logic [2:0] f3, input logic [31:0] addr,
                         input int exp_ill, input int exp_mis, input string tag);
    int t, men0, wb0, ill0, mis0;
    @(negedge clk);
    drive(sel, 1'b1, f3, addr, 5'd9);
    #1;
    t    = cyc;
    men0 = men_cnt[sel];
    wb0  = wb_cnt[sel];
    ill0 = ill_cnt[sel];
    mis0 = mis_cnt[sel];
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 3'b000, 32'h0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_ill"}, 64'(ill_cnt[sel] - ill0), 64'(exp_ill));
    check({tag, "_mis"}, 64'(mis_cnt[sel] - mis0), 64'(exp_mis));
    check({tag, "_err_cyc"}, 64'(err_cyc[sel]), 64'(t + 1));
    check({tag, "_err_addr"}, 64'(err_addr[sel]), 64'(addr));
    check({tag, "_no_men"}, 64'(men_cnt[sel] - men0), 64'd0);
    check({tag, "_no_wb"}, 64'(wb_cnt[sel] - wb0), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, men0, wb0, first, second;
    logic rdy_bad, rdy_resp;

    rstn = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 3'b000, 32'h0, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(a.req_ready_o), 64'd0);
    check("rst_mem_en", 64'(a.mem_en_o), 64'd0);
    check("rst_wb_valid", 64'(a.wb_valid_o), 64'd0);
    check("rst_errs", 64'({a.err_illegal_o, a.err_misaligned_o}), 64'd0);
    check("rst_wb_data", 64'(a.wb_data_o), 64'd0);
    check("rst_err_addr", 64'(a.err_addr_o), 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rel_ready", 64'(a.req_ready_o), 64'd1);

    // 32-bit, READ_LATENCY=1, word@0 = 0x8F7FFF0F
    run_load(0, 3'b100, 32'h1, 5'd30, 64'h0000_00FF, 32'h0, "lbu1");
    run_load(0, 3'b000, 32'h1, 5'd31, 64'hFFFF_FFFF, 32'h0, "lb1");
    run_load(0, 3'b100, 32'h0, 5'd15, 64'h0000_000F, 32'h0, "lbu0");
    run_load(0, 3'b000, 32'h3, 5'd6,  64'hFFFF_FF8F, 32'h0, "lb3");
    run_load(0, 3'b001, 32'h2, 5'd1,  64'hFFFF_8F7F, 32'h0, "lh2");
    run_load(0, 3'b101, 32'h2, 5'd2,  64'h0000_8F7F, 32'h0, "lhu2");
    run_load(0, 3'b001, 32'h0, 5'd4,  64'hFFFF_FF0F, 32'h0, "lh0");
    run_load(0, 3'b010, 32'h0, 5'd3,  64'h8F7F_FF0F, 32'h0, "lw0");
    run_load(0, 3'b000, 32'h4, 5'd5,  64'hFFFF_FF80, 32'h4, "lb4");
    run_load(0, 3'b100, 32'h1, 5'd0,  64'h0,         32'h0, "lbu_rd0");

    run_err(0, 3'b010, 32'h5, 0, 1, "lw5_mis");
    run_err(0, 3'b001, 32'h3, 0, 1, "lh3_mis");
    run_err(0, 3'b011, 32'h1, 1, 0, "ld32_ill");
    run_err(0, 3'b110, 32'h0, 1, 0, "lwu32_ill");
    run_err(0, 3'b111, 32'h0, 1, 0, "f7_ill");

    // READ_LATENCY=3, valid held high across two loads
    @(negedge clk);
    drive(1, 1'b1, 3'b100, 32'h1, 5'd7);
    #1;
    t = cyc; men0 = men_cnt[1]; wb0 = wb_cnt[1];
    first = -1; second = -1; rdy_bad = 1'b0; rdy_resp = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      #1;
      if (((i >= 1 && i <= 4) || (i >= 6 && i <= 9)) && b.req_ready_o) rdy_bad = 1'b1;
      if (i == 5) rdy_resp = b.req_ready_o;
      if (wb_cnt[1] - wb0 == 1 && first < 0) first = cyc;
      if (wb_cnt[1] - wb0 == 2 && second < 0) begin
        second = cyc;
        drive(1, 1'b0, 3'b000, 32'h0, 5'd0);
      end
    end
    drive(1, 1'b0, 3'b000, 32'h0, 5'd0);
    check("b2b_wb1_cyc", 64'(first), 64'(t + 5));
    check("b2b_wb2_cyc", 64'(second), 64'(t + 10));
    check("b2b_men_cnt", 64'(men_cnt[1] - men0), 64'd2);
    check("b2b_busy_ready", 64'(rdy_bad), 64'd0);
    check("b2b_resp_ready", 64'(rdy_resp), 64'd1);
    check("b2b_data", wb_data[1], 64'h0000_00FF);
    run_load(1, 3'b010, 32'h4, 5'd8, 64'h0000_0080, 32'h4, "rl3_lw4");

    // Reset right after mem_en_o
    @(negedge clk);
    drive(0, 1'b1, 3'b100, 32'h1, 5'd5);
    #1;
    men0 = men_cnt[0]; wb0 = wb_cnt[0];
    @(posedge clk);
    #1 drive(0, 1'b0, 3'b000, 32'h0, 5'd0);
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_low", 64'(a.req_ready_o), 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 64'(a.req_ready_o), 64'd1);
    check("mid_rst_wb_data", 64'(a.wb_data_o), 64'd0);
    check("mid_rst_wb_rd", 64'(a.wb_rd_o), 64'd0);
    check("mid_rst_mem_addr", 64'(a.mem_addr_o), 64'd0);
    check("mid_rst_err_addr", 64'(a.err_addr_o), 64'd0);
    check("mid_rst_strobes", 64'({a.mem_en_o, a.wb_valid_o, a.err_illegal_o, a.err_misaligned_o}), 64'd0);
    repeat (4) @(negedge clk);
    #1;
    check("mid_rst_men", 64'(men_cnt[0] - men0), 64'd1);
    check("mid_rst_no_wb", 64'(wb_cnt[0] - wb0), 64'd0);
    run_load(0, 3'b100, 32'h0, 5'd15, 64'h0000_000F, 32'h0, "post_rst_lbu");

    // 64-bit, word@0x8 = 0x8000000000000001
    run_load(2, 3'b011, 32'h8, 5'd10, 64'h8000_0000_0000_0001, 32'h8, "ld8");
    run_load(2, 3'b110, 32'hC, 5'd11, 64'h0000_0000_8000_0000, 32'h8, "lwuC");
    run_load(2, 3'b010, 32'hC, 5'd12, 64'hFFFF_FFFF_8000_0000, 32'h8, "lwC");
    run_load(2, 3'b000, 32'hF, 5'd13, 64'hFFFF_FFFF_FFFF_FF80, 32'h8, "lbF");
    run_load(2, 3'b100, 32'h8, 5'd0,  64'h0,                   32'h8, "lbu64_rd0");
    run_err(2, 3'b011, 32'hC, 0, 1, "ldC_mis");
    run_err(2, 3'b110, 32'hA, 0, 1, "lwuA_mis");
    run_err(2, 3'b111, 32'h3, 1, 0, "f7_64_ill");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jedro_1_load_unit.md
Name: jedro_1_load_unit

Overview:
Parametrised load unit for the jedro_1 core. It sits between the decoder/execute stage and the data-memory read port. It accepts one load request at a time and issues a single aligned word read. After a configurable memory read latency it extracts the byte, halfword, word or doubleword lane, sign- or zero-extends it, and presents it to regfile writeback. It is the successor to the fixed 32-bit byte/half load path: it adds data-width generalisation (RV64 ld/lwu), configurable read latency, misalignment and illegal-funct3 detection.

Parameters:
DATA_WIDTH, 32, memory/register width; legal values 32 or 64.
ADDR_WIDTH, 32, byte address width.
REG_ADDR_WIDTH, 5, destination register index width.
READ_LATENCY, 1, cycles from mem_en_o high to mem_rdata_i valid; legal range 1..4.

Ports:
clk_i  in  1  core clock; all logic on rising edge.
rstn_i  in  1  reset, synchronous, active-low.
req_valid_i  in  1  load request valid.
req_ready_o  out  1  unit can accept a request.
req_funct3_i  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; 011 ld and 110 lwu only when DATA_WIDTH=64.
req_addr_i  in  ADDR_WIDTH  byte address.
req_rd_i  in  REG_ADDR_WIDTH  destination register.
mem_en_o  out  1  one-cycle read strobe.
mem_addr_o  out  ADDR_WIDTH  word-aligned address; low log2(DATA_WIDTH/8) bits are 0.
mem_rdata_i  in  DATA_WIDTH  read data.
wb_valid_o  out  1  one-cycle writeback strobe.
wb_rd_o  out  REG_ADDR_WIDTH  writeback register.
wb_data_o  out  DATA_WIDTH  extended load result.
err_misaligned_o  out  1  one-cycle misaligned-access pulse.
err_illegal_o  out  1  one-cycle illegal-funct3 pulse.
err_addr_o  out  ADDR_WIDTH  faulting byte address.

Behaviour:
- Reset (rstn_i=0 at a rising edge):
  - State goes to IDLE.
  - mem_en_o, wb_valid_o, err_* are 0.
  - mem_addr_o, wb_rd_o, wb_data_o, err_addr_o are 0.
  - req_ready_o is 0 while rstn_i is low and 1 in the first cycle after release.
- States: IDLE, ISSUE, WAIT, RESP, ERR.
- Accept: a request is accepted at the edge where req_valid_i && req_ready_o. req_ready_o=1 only in IDLE and RESP. Request fields are registered on accept.
- Check on accept:
  - Illegal funct3 → ERR; this check has priority over misalignment.
  - Misaligned → ERR. Misaligned means: lh/lhu with addr[0]≠0; lw/lwu with addr[1:0]≠0; ld with addr[2:0]≠0.
  - Otherwise → ISSUE.
- ERR: err_illegal_o or err_misaligned_o high for one cycle, err_addr_o = request address. No mem_en_o, no wb_valid_o. Next state IDLE.
- ISSUE: mem_en_o=1 for exactly one cycle with the aligned mem_addr_o. Load counter with READ_LATENCY. Go to WAIT.
- WAIT: decrement the counter each cycle. Capture mem_rdata_i in cycle ISSUE+READ_LATENCY, then go to RESP.
- RESP:
  - wb_valid_o=1 for one cycle with wb_rd_o and wb_data_o.
  - A new request may be accepted in this cycle (→ ISSUE/ERR); otherwise go to IDLE.
- Latency: accept edge at cycle T → mem_en_o in T+1 → wb_valid_o in T+READ_LATENCY+2. Back-to-back throughput is one load per READ_LATENCY+2 cycles.
- Extraction: lane = mem_rdata_i >> (8 × byte offset), where byte offset = addr[log2(DATA_WIDTH/8)-1:0]. lb/lh/lw sign-extend from bit 7/15/31. lbu/lhu/lwu zero-extend. ld passes the full word.
- rd=0: the memory read is still performed, but wb_valid_o stays 0.
- wb_data_o, wb_rd_o and err_addr_o hold their last value between pulses.
- Reset mid-operation (ISSUE/WAIT/RESP): the pending load is discarded, no wb_valid_o is produced, and a late mem_rdata_i is ignored.
- req_valid_i while busy (WAIT/ISSUE/ERR): not accepted; the requester holds its fields stable.

Test Plan:
- DATA_WIDTH=32, READ_LATENCY=1, word@0x0=0x8F7FFF0F:
  - lbu 0x1 rd=30 → wb_data_o=0x000000FF at accept+3.
  - lb 0x1 rd=31 → 0xFFFFFFFF.
  - lbu 0x0 rd=15 → 0x0000000F.
- Same word: lh 0x2 → 0xFFFF8F7F; lhu 0x2 → 0x00008F7F; lw 0x0 → 0x8F7FFF0F; mem_addr_o=0x0 in all cases.
- Error cases:
  - lw 0x5 → err_misaligned_o one cycle, err_addr_o=0x5, no mem_en_o/wb_valid_o.
  - funct3=011 at DATA_WIDTH=32 → err_illegal_o, not err_misaligned_o, even with a misaligned address.
- READ_LATENCY=3, req_valid_i held high for two loads → mem_en_o once per load; wb_valid_o pulses at accept+5 and 5 cycles later; req_ready_o low in ISSUE/WAIT.
- rstn_i low for one cycle immediately after mem_en_o → no wb_valid_o, all outputs 0; req_ready_o=1 in the first cycle after release; a subsequent lbu completes correctly.
- DATA_WIDTH=64, word@0x8=0x8000000000000001:
  - ld 0x8 → 0x8000000000000001.
  - lwu 0xC → 0x0000000080000000.
  - lw 0xC → 0xFFFFFFFF80000000.
  - lbu with rd=0 → mem_en_o pulses, no wb_valid_o.
